// File: rtl/gnw_pkg.sv
// Shared types and helpers for the LCD frame capture block.
// LCD geometry, read-address layout and common-strobe decode helpers.
package gnw_pkg;

    localparam int unsigned LCD_COMMONS = 4;
    localparam int unsigned LCD_SEGS    = 32;

    typedef logic [1:0] common_idx_t;
    typedef logic [4:0] seg_idx_t;

    // Read address layout: {common[1:0], seg[4:0]}
    typedef struct packed {
        common_idx_t common;
        seg_idx_t    seg;
    } lcd_addr_t;

    // Flat index of a segment cell for a given read address
    function automatic int unsigned addr_index(input lcd_addr_t a);
        return int'(a.common) * LCD_SEGS + int'(a.seg);
    endfunction

    // True when exactly one common strobe is active
    function automatic logic is_onehot4(input logic [3:0] h);
        return $onehot(h);
    endfunction

    // Encode a one-hot common strobe into its index (0 for non-one-hot)
    function automatic common_idx_t encode_common(input logic [3:0] h);
        common_idx_t c;
        c = '0;
        case (h)
            4'b0001: c = 2'd0;
            4'b0010: c = 2'd1;
            4'b0100: c = 2'd2;
            4'b1000: c = 2'd3;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_frame_capture_if.sv
// LCD driver input bus and renderer read port of lcd_frame_capture.
// master: core/renderer side, slave: the capture block.
interface lcd_frame_capture_if
    import gnw_pkg::*;
#(
    parameter int unsigned PERSIST_W = 4
);

    logic [15:0]          segA;
    logic [15:0]          segB;
    logic [3:0]           H;
    logic                 Bs;
    lcd_addr_t            rd_addr;
    logic                 rd_lit;
    logic [PERSIST_W-1:0] rd_level;
    logic [3:0]           bs_lit;
    logic                 frame_done;
    logic                 stalled;

    modport master (
        output segA, segB, H, Bs, rd_addr,
        input  rd_lit, rd_level, bs_lit, frame_done, stalled
    );

    modport slave (
        input  segA, segB, H, Bs, rd_addr,
        output rd_lit, rd_level, bs_lit, frame_done, stalled
    );

endinterface

// File: rtl/lcd_persist_cell.sv
// One LCD segment persistence cell.
// With LCD_GHOST_EN defined the cell is a saturating decay counter;
// otherwise it is a single bit holding the last captured segment value.
module lcd_persist_cell #(
    parameter int unsigned PERSIST_W   = 4,
    parameter int unsigned PERSIST_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 capture,
    input  logic                 clear,
    input  logic                 seg_on,
    output logic [PERSIST_W-1:0] level
);

`ifdef LCD_GHOST_EN
    localparam logic [PERSIST_W-1:0] LVL_MAX = PERSIST_W'(PERSIST_MAX);
    localparam logic [PERSIST_W-1:0] LVL_ONE = PERSIST_W'(1);

    logic [PERSIST_W-1:0] cnt;

    // Reload on drive, decay towards zero without wrapping, blank on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (capture) begin
            if (seg_on)
                cnt <= LVL_MAX;
            else if (cnt != '0)
                cnt <= cnt - LVL_ONE;
        end
    end

    assign level = cnt;
`else
    logic                 seg_bit;
    logic [PERSIST_W-1:0] unused_max;

    // Hold the last captured value, blank on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seg_bit <= 1'b0;
        else if (clear)
            seg_bit <= 1'b0;
        else if (capture)
            seg_bit <= seg_on;
    end

    assign level      = {{(PERSIST_W-1){1'b0}}, seg_bit};
    assign unused_max = PERSIST_W'(PERSIST_MAX);
`endif

endmodule

// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture: demultiplexes SM510 LCD common/segment drive into a
// persistent 4x32 segment bitmap with a registered random-access read port,
// frame-done pulse and stall watchdog. Optional macro: LCD_GHOST_EN.
module lcd_frame_capture
    import gnw_pkg::*;
#(
    parameter int unsigned PERSIST_W    = 4,
    parameter int unsigned PERSIST_MAX  = 15,
    parameter int unsigned STALL_CYCLES = 65536
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_frame_capture_if.slave bus
);

    localparam int unsigned        STALL_W    = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_SAT  = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

    logic [31:0]              seg_q;
    logic [3:0]               h_q;
    logic [3:0]               h_prev;
    logic                     bs_q;
    logic                     capture;
    common_idx_t              cap_c;
    logic [LCD_COMMONS-1:0]   cap_sel;
    logic [STALL_W-1:0]       stall_cnt;
    logic                     stall_clear;
    logic [PERSIST_W-1:0]     level [LCD_COMMONS*LCD_SEGS];

    // Register the raw LCD driver lines and keep the previous common strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= '0;
            h_q    <= '0;
            h_prev <= '0;
            bs_q   <= 1'b0;
        end else begin
            seg_q  <= {bus.segB, bus.segA};
            h_q    <= bus.H;
            h_prev <= h_q;
            bs_q   <= bus.Bs;
        end
    end

    // A capture is a change of the registered strobe to a one-hot value;
    // blanking fires on the cycle the watchdog reaches its limit and keeps
    // the display dark until the next capture.
    always_comb begin
        capture     = (h_q != h_prev) && is_onehot4(h_q);
        cap_c       = encode_common(h_q);
        cap_sel     = '0;
        if (capture)
            cap_sel[cap_c] = 1'b1;
        stall_clear = !capture && (stall_cnt >= STALL_LAST);
    end

    // Watchdog: count cycles since the last capture, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            bus.stalled <= 1'b0;
        end else if (capture) begin
            stall_cnt   <= '0;
            bus.stalled <= 1'b0;
        end else begin
            if (stall_cnt != STALL_SAT)
                stall_cnt <= stall_cnt + STALL_ONE;
            if (stall_clear)
                bus.stalled <= 1'b1;
        end
    end

    // Per-common Bs latch and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bs_lit     <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= capture && (cap_c == 2'd3);
            if (stall_clear)
                bus.bs_lit <= '0;
            else if (capture)
                bus.bs_lit[cap_c] <= bs_q;
        end
    end

    genvar gc, gs;
    generate
        for (gc = 0; gc < LCD_COMMONS; gc++) begin : g_common
            for (gs = 0; gs < LCD_SEGS; gs++) begin : g_seg
                lcd_persist_cell #(
                    .PERSIST_W   (PERSIST_W),
                    .PERSIST_MAX (PERSIST_MAX)
                ) u_cell (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .capture (cap_sel[gc]),
                    .clear   (stall_clear),
                    .seg_on  (seg_q[gs]),
                    .level   (level[gc*LCD_SEGS + gs])
                );
            end
        end
    endgenerate

    // Registered read port; a same-cycle capture returns the pre-update level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_level <= '0;
            bus.rd_lit   <= 1'b0;
        end else begin
            bus.rd_level <= level[addr_index(bus.rd_addr)];
            bus.rd_lit   <= (level[addr_index(bus.rd_addr)] != '0);
        end
    end

endmodule
